// File: rtl/joypad_ctrl_db.sv
// joypad_ctrl_db: JOYP register with per-button sync and debounce,
// select-line multiplexing and a sticky key-press interrupt.
module joypad_ctrl_db #(
  parameter logic [15:0] ADDR            = 16'hFF00,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        int_ack,
  output logic        int_req,
  input  logic [15:0] A,
  input  logic [7:0]  Di,
  output logic [7:0]  Do,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        cs,
  input  logic [7:0]  btn_raw,
  output logic [7:0]  btn_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]    sync_q [SYNC_STAGES];
  logic [7:0]    sync_d [SYNC_STAGES];
  logic [CW-1:0] cnt_q  [8];
  logic [CW-1:0] cnt_d  [8];
  logic [7:0]    btn_q, btn_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    nib_q, nib_d;
  logic          int_q, int_d;
  logic [7:0]    s;
  logic [3:0]    nib;
  logic          hit;
  logic          unused_in;

  assign unused_in = ^{rd_n, Di[7:6], Di[3:0]};

  assign s   = sync_q[SYNC_STAGES-1];
  assign hit = cs && (A == ADDR);

  always_comb begin
    sync_d[0] = btn_raw;
    for (int j = 1; j < SYNC_STAGES; j++) begin
      sync_d[j] = sync_q[j-1];
    end
  end

  // Any cycle where s matches the debounced state restarts the count
  always_comb begin
    btn_d = btn_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (s[i] != btn_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          btn_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign nib = ~(({4{~sel_q[0]}} & btn_q[3:0]) |
                 ({4{~sel_q[1]}} & btn_q[7:4]));

  always_comb begin
    sel_d = sel_q;
    if (hit && !wr_n) begin
      sel_d = Di[5:4];
    end
    nib_d = nib;
    int_d = int_q;
    if (int_ack) begin
      int_d = 1'b0;
    end
    if ((nib_q & ~nib) != 4'h0) begin
      int_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= 8'h00;
      end
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
      btn_q <= 8'h00;
      sel_q <= 2'b11;
      nib_q <= 4'hF;
      int_q <= 1'b0;
    end else begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_d[j];
      end
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      btn_q <= btn_d;
      sel_q <= sel_d;
      nib_q <= nib_d;
      int_q <= int_d;
    end
  end

  assign Do        = hit ? {2'b11, sel_q, nib} : 8'hFF;
  assign int_req   = int_q;
  assign btn_state = btn_q;

endmodule

// File: tb/tb_joypad_ctrl_db.sv
// tb_joypad_ctrl_db: directed vectors and a randomized run against
// a run-length reference model of the joypad controller.
module tb_joypad_ctrl_db;

  localparam logic [15:0] ADDR = 16'hFF00;
  localparam int SYNC = 2;
  localparam int DB   = 8;

  logic        clock;
  logic        reset;
  logic        int_ack;
  logic        int_req;
  logic [15:0] A;
  logic [7:0]  Di;
  logic [7:0]  Do;
  logic        rd_n;
  logic        wr_n;
  logic        cs;
  logic [7:0]  btn_raw;
  logic [7:0]  btn_state;

  int checks = 0;
  int failures = 0;

  joypad_ctrl_db #(
    .ADDR(ADDR),
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .int_ack(int_ack),
    .int_req(int_req),
    .A(A),
    .Di(Di),
    .Do(Do),
    .rd_n(rd_n),
    .wr_n(wr_n),
    .cs(cs),
    .btn_raw(btn_raw),
    .btn_state(btn_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  logic [7:0] m_hist [SYNC];
  int         m_run  [8];
  logic [7:0] m_state;
  logic [1:0] m_sel;
  logic [3:0] m_nibq;
  logic       m_int;

  function automatic logic [3:0] m_nib();
    logic [3:0] mask;
    mask = 4'h0;
    if (!m_sel[0]) mask = mask | m_state[3:0];
    if (!m_sel[1]) mask = mask | m_state[7:4];
    return ~mask;
  endfunction

  function automatic logic [7:0] m_do();
    if (cs && A == ADDR) return {2'b11, m_sel, m_nib()};
    return 8'hFF;
  endfunction

  task automatic model_step();
    logic [7:0] s_now;
    logic [3:0] n_now;
    if (reset) begin
      for (int j = 0; j < SYNC; j++) m_hist[j] = 8'h00;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      m_state = 8'h00;
      m_sel   = 2'b11;
      m_nibq  = 4'hF;
      m_int   = 1'b0;
    end else begin
      n_now = m_nib();
      if ((m_nibq & ~n_now) != 4'h0) m_int = 1'b1;
      else if (int_ack) m_int = 1'b0;
      m_nibq = n_now;
      if (cs && !wr_n && A == ADDR) m_sel = Di[5:4];
      s_now = m_hist[0];
      for (int i = 0; i < 8; i++) begin
        if (s_now[i] != m_state[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_state[i] = s_now[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      for (int j = 0; j < SYNC - 1; j++) m_hist[j] = m_hist[j+1];
      m_hist[SYNC-1] = btn_raw;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic c,
                    input logic [7:0] d);
    A = a;
    cs = c;
    Di = d;
    wr_n = 1'b0;
    tick();
    wr_n = 1'b1;
    A = ADDR;
    cs = 1'b1;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic        cs;
    logic        wr_n;
    logic [7:0]  di;
    logic [7:0]  exp_do;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{ADDR,     1'b1, 1'b0, 8'h20, 8'hEE};
    tbl[1] = '{ADDR,     1'b1, 1'b0, 8'h10, 8'hD7};
    tbl[2] = '{ADDR,     1'b1, 1'b0, 8'h00, 8'hC6};
    tbl[3] = '{ADDR,     1'b1, 1'b0, 8'h30, 8'hFF};
    tbl[4] = '{ADDR,     1'b1, 1'b0, 8'hE2, 8'hEE};
    tbl[5] = '{16'hFF01, 1'b1, 1'b0, 8'h10, 8'hEE};
    tbl[6] = '{ADDR,     1'b0, 1'b0, 8'h10, 8'hEE};
    tbl[7] = '{ADDR,     1'b1, 1'b1, 8'h10, 8'hEE};
    tbl[8] = '{ADDR,     1'b1, 1'b0, 8'h1F, 8'hD7};

    reset = 1'b1;
    int_ack = 1'b0;
    A = ADDR;
    Di = 8'h00;
    rd_n = 1'b0;
    wr_n = 1'b1;
    cs = 1'b1;
    btn_raw = 8'h00;

    // reset
    ticks(2);
    chk("reset_do", Do, 8'hFF);
    chk("reset_int", {7'd0, int_req}, 8'h00);
    chk("reset_btn", btn_state, 8'h00);
    reset = 1'b0;
    tick();

    // 7-cycle glitch is filtered, then a held press lands on edge 10
    btn_raw = 8'h10;
    ticks(7);
    btn_raw = 8'h00;
    ticks(12);
    chk("glitch", btn_state, 8'h00);
    btn_raw = 8'h10;
    ticks(9);
    chk("hold_edge9", btn_state, 8'h00);
    tick();
    chk("hold_edge10", btn_state, 8'h10);
    btn_raw = 8'h00;
    ticks(10);
    chk("release", btn_state, 8'h00);

    // select mux and write decode
    btn_raw = 8'h81;
    ticks(10);
    chk("btn_81", btn_state, 8'h81);
    for (int i = 0; i < 9; i++) begin
      A = tbl[i].a;
      cs = tbl[i].cs;
      wr_n = tbl[i].wr_n;
      Di = tbl[i].di;
      tick();
      wr_n = 1'b1;
      A = ADDR;
      cs = 1'b1;
      #1;
      chk($sformatf("sel_tbl%0d", i), Do, tbl[i].exp_do);
    end
    btn_raw = 8'h00;
    ticks(10);

    // interrupt and acknowledge
    wr(ADDR, 1'b1, 8'h20);
    ack();
    chk("int_cleared", {7'd0, int_req}, 8'h00);
    btn_raw = 8'h01;
    ticks(10);
    chk("int_btn", btn_state, 8'h01);
    chk("int_not_yet", {7'd0, int_req}, 8'h00);
    tick();
    chk("int_set", {7'd0, int_req}, 8'h01);
    ack();
    chk("int_ack", {7'd0, int_req}, 8'h00);
    btn_raw = 8'h00;
    ticks(12);
    chk("int_release", {7'd0, int_req}, 8'h00);

    // set beats ack in the same cycle
    btn_raw = 8'h01;
    ticks(10);
    chk("sim_btn", btn_state, 8'h01);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("sim_set_wins", {7'd0, int_req}, 8'h01);
    ack();
    btn_raw = 8'h00;
    ticks(10);

    // select write exposing a held key raises the interrupt
    wr(ADDR, 1'b1, 8'h30);
    ack();
    btn_raw = 8'h10;
    ticks(10);
    chk("selw_pre", {7'd0, int_req}, 8'h00);
    wr(ADDR, 1'b1, 8'h10);
    chk("selw_edge1", {7'd0, int_req}, 8'h00);
    tick();
    chk("selw_edge2", {7'd0, int_req}, 8'h01);
    ack();
    btn_raw = 8'h00;
    ticks(10);

    // chip select gates the read path
    cs = 1'b0;
    #1;
    chk("cs0_read", Do, 8'hFF);
    cs = 1'b1;

    // reset mid-debounce, with a concurrent write that must lose
    btn_raw = 8'h01;
    ticks(7);
    reset = 1'b1;
    wr_n = 1'b0;
    Di = 8'h00;
    tick();
    reset = 1'b0;
    wr_n = 1'b1;
    #1;
    chk("rst_sel", Do, 8'hFF);
    ticks(9);
    chk("rst_db_edge9", btn_state, 8'h00);
    tick();
    chk("rst_db_edge10", btn_state, 8'h01);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(5) == 0)
        btn_raw = btn_raw ^ (8'h01 << $urandom_range(7));
      int_ack = ($urandom_range(5) == 0);
      rd_n = 1'($urandom_range(1));
      case ($urandom_range(3))
        0: A = 16'hFF01;
        1: A = 16'($urandom);
        default: A = ADDR;
      endcase
      cs = ($urandom_range(7) != 0);
      wr_n = ($urandom_range(7) != 0);
      Di = 8'($urandom);
      tick();
      chk("rnd_btn", btn_state, m_state);
      chk("rnd_int", {7'd0, int_req}, {7'd0, m_int});
      chk("rnd_do", Do, m_do());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
